// File: rtl/parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parser_pkg
// Description : Shared types and constants for the rule configuration
//               arbiter: arbiter FSM states and the rule-address select field.
// Revision    : 1.0 - initial release
// ============================================================================
package parser_pkg;

    // Arbiter lock state
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } cfg_arb_state_t;

    // Address field that selects the target table; RULE_SEL marks a rule write
    localparam int          RULE_SEL_MSB = 10;
    localparam int          RULE_SEL_LSB = 8;
    localparam logic [2:0]  RULE_SEL     = 3'd0;

    // A rule write completes a configuration transaction (commit)
    function automatic logic is_commit(input logic [31:0] addr);
        return addr[RULE_SEL_MSB:RULE_SEL_LSB] == RULE_SEL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first active
//               request at or above ptr_i, wrapping around to index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int REQ_NUM = 2
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [REQ_NUM-1:0] gnt_o
);

    logic w_found;

    // Two passes: first the upper segment [ptr, N), then the wrapped [0, ptr)
    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        for (int j = 0; j < REQ_NUM; j++) begin
            if (!w_found && req_i[j] && (j >= int'(ptr_i))) begin
                gnt_o[j] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int j = 0; j < REQ_NUM; j++) begin
            if (!w_found && req_i[j] && (j < int'(ptr_i))) begin
                gnt_o[j] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rule_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module      : rule_cfg_arb
// Description : Arbitrates rule-configuration writes from several requesters.
//               Setup words lock the arbiter to one requester until it sends
//               a rule write (commit) or stays idle for LOCK_TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module rule_cfg_arb
    import parser_pkg::*;
#(
    parameter int REQ_NUM      = 2,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [REQ_NUM-1:0]       i_req_valid,
    input  logic [REQ_NUM-1:0][31:0] i_req_addr,
    input  logic [REQ_NUM-1:0][31:0] i_req_wdata,
    output logic [REQ_NUM-1:0]       o_req_ready,
    output logic                     o_rule_wren,
    output logic [31:0]              o_rule_addr,
    output logic [31:0]              o_rule_wdata,
    output logic [2:0]               o_grant_id,
    output logic                     o_busy,
    output logic [REQ_NUM-1:0]       o_timeout_err
);

    cfg_arb_state_t       state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           owner_q, owner_d;
    logic [7:0]           idle_cnt_q, idle_cnt_d;
    logic                 wren_q, wren_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [REQ_NUM-1:0]   err_q, err_d;

    logic [REQ_NUM-1:0]   w_arb_gnt;
    logic [REQ_NUM-1:0]   w_owner_oh;
    logic [REQ_NUM-1:0]   w_acc_vec;
    logic                 w_accept;
    logic [2:0]           w_acc_idx;
    logic [31:0]          w_acc_addr;
    logic [31:0]          w_acc_wdata;
    logic                 w_commit;

    function automatic logic [2:0] f_next(input logic [2:0] idx);
        return (idx == 3'(REQ_NUM - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    rr_arbiter #(
        .REQ_NUM (REQ_NUM)
    ) u_rr_arbiter (
        .req_i (i_req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (w_arb_gnt)
    );

    generate
        for (genvar g = 0; g < REQ_NUM; g++) begin : g_owner_oh
            assign w_owner_oh[g] = (owner_q == 3'(g));
        end
    endgenerate

    // Ready: arbiter winner when idle, only the owner when locked; none in reset
    always_comb begin
        o_req_ready = (state_q == ST_LOCKED) ? w_owner_oh : w_arb_gnt;
        if (!i_rst_n) begin
            o_req_ready = '0;
        end
    end

    assign w_acc_vec = i_req_valid & o_req_ready;
    assign w_accept  = |w_acc_vec;

    // Select the accepted word (at most one requester is ready at a time)
    always_comb begin
        w_acc_idx   = 3'd0;
        w_acc_addr  = '0;
        w_acc_wdata = '0;
        for (int j = 0; j < REQ_NUM; j++) begin
            if (w_acc_vec[j]) begin
                w_acc_idx   = 3'(j);
                w_acc_addr  = i_req_addr[j];
                w_acc_wdata = i_req_wdata[j];
            end
        end
    end

    assign w_commit = is_commit(w_acc_addr);

    // Next-state: lock on setup, release on commit or idle timeout
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        err_d      = '0;
        wren_d     = w_accept;
        addr_d     = w_accept ? w_acc_addr  : addr_q;
        wdata_d    = w_accept ? w_acc_wdata : wdata_q;
        grant_d    = w_accept ? w_acc_idx   : grant_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_commit) begin
                        rr_ptr_d = f_next(w_acc_idx);
                    end else begin
                        state_d    = ST_LOCKED;
                        owner_d    = w_acc_idx;
                        idle_cnt_d = 8'd0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_accept) begin
                    idle_cnt_d = 8'd0;
                    if (w_commit) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = f_next(owner_q);
                    end
                end else if (idle_cnt_q + 8'd1 == 8'(LOCK_TIMEOUT)) begin
                    err_d      = w_owner_oh;
                    state_d    = ST_IDLE;
                    rr_ptr_d   = f_next(owner_q);
                    idle_cnt_d = 8'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_LOCKED);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 3'd0;
            owner_q    <= 3'd0;
            idle_cnt_q <= 8'd0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            grant_q    <= 3'd0;
            busy_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            idle_cnt_q <= idle_cnt_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign o_rule_wren   = wren_q;
    assign o_rule_addr   = addr_q;
    assign o_rule_wdata  = wdata_q;
    assign o_grant_id    = grant_q;
    assign o_busy        = busy_q;
    assign o_timeout_err = err_q;

endmodule
`default_nettype wire
